timer_sequencer: RTL

Avalon-MM master-side controller that programs and services the system's 16-bit-register interval timer peripheral on behalf of hardware logic, with no CPU involvement. On a start request it loads the 32-bit period, starts the timer in continuous mode with interrupt enabled, and acknowledges each timeout. It counts timeouts and emits tick pulses, then stops the timer after a programmed number of ticks or on request. It sits between a hardware client and the timer's s1 slave port and irq line.

---
 rtl/timer_sequencer_if.sv | 25 ++
 rtl/timer_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/timer_sequencer_if.sv
// Avalon-MM write-only link between the sequencer and the interval timer s1 port,
// plus the timer's level interrupt.
interface timer_sequencer_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_irq;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_irq
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_irq
    );
endinterface

// File: rtl/timer_sequencer.sv
// Hardware-driven programming and servicing of a 16-bit-register interval timer:
// load period, run continuous with IRQ, acknowledge timeouts, stop on count or request.
//
// state      | meaning
// IDLE       | waiting for start; latches period/count
// WR_PL      | writing period[15:0] to address 2
// WR_PH      | writing period[31:16] to address 3
// WR_CTRL    | writing ITO|CONT|START to control
// WAIT_IRQ   | timer running, waiting for timeout or pending stop
// CLR        | clearing timeout status, tick pulse, ticks+1
// WR_STOP    | writing STOP to control
// DONE       | done pulse, busy low
module timer_sequencer #(
    parameter int unsigned MIN_PERIOD = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [31:0]        period,
    input  logic [15:0]        count,
    output logic               busy,
    output logic               tick,
    output logic               done,
    output logic [15:0]        ticks,
    timer_sequencer_if.master  tmr
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_WAIT_IRQ, S_CLR, S_WR_STOP, S_DONE
    } state_t;

    localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);

    state_t      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic [15:0] count_q, count_d;
    logic [15:0] ticks_q, ticks_d;
    logic        stop_pend_q, stop_pend_d;
    logic        busy_q, busy_d;
    logic        tick_q, tick_d;
    logic        done_q, done_d;
    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        accept;

    assign accept = (state_q == S_IDLE) && start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (start) state_d = S_WR_PL;
            S_WR_PL:    state_d = S_WR_PH;
            S_WR_PH:    state_d = S_WR_CTRL;
            S_WR_CTRL:  state_d = S_WAIT_IRQ;
            S_WAIT_IRQ: begin
                // A timeout that coincides with a stop is still acknowledged first.
                if (tmr.tmr_irq)       state_d = S_CLR;
                else if (stop_pend_q)  state_d = S_WR_STOP;
            end
            S_CLR: begin
                // ticks_q already holds the incremented value during CLR.
                if (stop_pend_q || (count_q != 16'd0 && ticks_q == count_q))
                    state_d = S_WR_STOP;
                else
                    state_d = S_WAIT_IRQ;
            end
            S_WR_STOP:  state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        period_d    = period_q;
        count_d     = count_q;
        ticks_d     = ticks_q;
        stop_pend_d = stop_pend_q;
        if (accept) begin
            period_d    = (period < MIN_P) ? MIN_P : period;
            count_d     = count;
            ticks_d     = 16'd0;
            stop_pend_d = 1'b0;
        end else begin
            if (state_d == S_CLR) ticks_d = ticks_q + 16'd1;
            if (stop && state_q != S_IDLE && state_q != S_DONE) stop_pend_d = 1'b1;
        end
    end

    // Outputs are decoded from the next state so the registered bus lines up with the state.
    always_comb begin
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = 3'd0;
        wdata_d = 16'd0;
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        tick_d  = (state_d == S_CLR);
        done_d  = (state_d == S_DONE);
        unique case (state_d)
            S_WR_PL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wdata_d = period_d[15:0];  end
            S_WR_PH:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wdata_d = period_d[31:16]; end
            S_WR_CTRL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0007;       end
            S_CLR:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; wdata_d = 16'h0000;       end
            S_WR_STOP: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0008;       end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q    <= 32'd0;
            count_q     <= 16'd0;
            ticks_q     <= 16'd0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b0;
            wn_q        <= 1'b1;
            addr_q      <= 3'd0;
            wdata_q     <= 16'd0;
        end else begin
            period_q    <= period_d;
            count_q     <= count_d;
            ticks_q     <= ticks_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= busy_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
            cs_q        <= cs_d;
            wn_q        <= wn_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign busy               = busy_q;
    assign tick               = tick_q;
    assign done               = done_q;
    assign ticks              = ticks_q;
    assign tmr.tmr_chipselect = cs_q;
    assign tmr.tmr_write_n    = wn_q;
    assign tmr.tmr_address    = addr_q;
    assign tmr.tmr_writedata  = wdata_q;

endmodule
